bram_copy_sequencer: RTL
========================

Name: bram_copy_sequencer

Overview:
Sequences a block copy of N 32-bit words from a source BRAM region (read port A) to a destination BRAM region (write port B). It is started by a one-cycle `start` pulse and reports completion with `busy` and a `done` pulse. It sits between the frame-buffer BRAMs and the control logic that moves image tiles into the systolic-array input buffer. Every written word is masked to 24-bit pixel data (byte 3 forced to zero).

Parameters:
READ_LAT, 1, BRAM read latency in cycles; legal values are 1 and 2.
MAX_WORDS, 7056, upper clamp on the transfer length in words.
CNT_W, 13, width of the word-count and index counters.

Ports:
clk  input  1  system clock; also drives clka and clkb.
rstn  input  1  reset.
start  input  1  one-cycle request; sampled only in IDLE.
abort  input  1  cancels the transfer in progress.
src_base  input  32  source byte address; bits [1:0] are ignored.
dst_base  input  32  destination byte address; bits [1:0] are ignored.
word_cnt  input  CNT_W  number of words to copy.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse at normal completion.
clka  output  1  equals clk.
rsta  output  1  equals ~rstn.
ena  output  1  read enable.
addra  output  32  read byte address.
dina  output  32  constant 0.
wea  output  4  constant 4'b0000.
douta  input  32  read data from port A.
clkb  output  1  equals clk.
rstb  output  1  equals ~rstn.
enb  output  1  write enable.
addrb  output  32  write byte address.
dinb  output  32  write data.
web  output  4  byte write enables.
doutb  input  32  unused.

Behaviour:
- One clock, `clk`. Reset `rstn` is synchronous and active-low.
- Reset values:
  - State is IDLE.
  - busy, done, ena, enb are 0.
  - addra, addrb, dinb are 0; web is 0.
  - All counters and the pipeline valid bits are cleared.
- State machine: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On `start` at cycle T, latch {src_base[31:2],2'b00}, {dst_base[31:2],2'b00} and N.
  - N = min(word_cnt, MAX_WORDS).
  - If N = 0, go to DONE; no BRAM access occurs.
  - If N > 0, go to READ.
- READ:
  - Every cycle: ena=1, addra = src + 4*rd_idx, rd_idx increments.
  - Push a valid bit into a READ_LAT-deep shift register.
  - After the read with rd_idx = N-1 is issued, go to DRAIN.
- Write path:
  - When a valid bit exits the shift register: enb=1, web=4'hF, addrb = dst + 4*wr_idx, dinb = {8'h00, douta[23:0]}, wr_idx increments.
  - In all other cycles: enb=0, web=0.
- DRAIN:
  - Stays here until the write with wr_idx = N-1 has been performed, then goes to DONE.
  - When READ_LAT=1, the final write can coincide with the READ->DRAIN transition; DRAIN then lasts exactly one cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing for N > 0:
  - First read at T+1; last read at T+N.
  - First write at T+1+READ_LAT; last write at T+N+READ_LAT.
  - done at T+N+READ_LAT+1.
  - busy is high from T+1 through the done cycle inclusive.
- Timing for N = 0: busy=1 and done=1 at T+1; IDLE at T+2.
- Address arithmetic is 32-bit and wraps modulo 2^32 without error.
- `start` while busy is ignored; it is not queued.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - ena, enb and web are 0 from the next cycle.
  - Pending valid bits are flushed; no done pulse is produced.
  - abort takes precedence over a same-cycle transition to DONE.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: abort wins and start is dropped.
- Reset mid-transfer behaves like abort and additionally restores all reset values.

Test Plan:
- READ_LAT=1, src=0x100, dst=0x2000, N=4, douta returns 0xAB000000|addr -> addra 0x100,0x104,0x108,0x10C at T+1..T+4; writes at 0x2000..0x200C at T+2..T+5 with dinb upper byte 0x00; done at T+6; busy high T+1..T+6.
- READ_LAT=2, N=3 -> writes at T+3..T+5; done at T+6; exactly 3 web=4'hF cycles.
- word_cnt=0 -> no ena/enb cycles; done=1 at T+1; busy low at T+2.
- word_cnt=8000 -> exactly 7056 writes; last addrb = dst+4*7055; then done.
- abort asserted at T+3 with N=10 -> no ena/enb from T+4; no done; a new start at T+6 with N=2 completes normally.
- start pulsed again while busy, and src_base=0xFFFFFFFC with N=2 -> second start ignored; addra = 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/bram_copy_sequencer.sv
// bram_copy_sequencer
// Copies N 32-bit words from a source BRAM region (port A, read) to a
// destination BRAM region (port B, write). Written words keep only the
// 24-bit pixel payload; byte 3 is forced to zero.
//
// Handshake: start is a single-cycle request honoured only while idle;
// busy stays high from the cycle after an accepted start through the done
// cycle; done pulses for one cycle on normal completion only; abort returns
// to idle on the next edge from any non-idle state and flushes reads in
// flight.
module bram_copy_sequencer #(
  parameter int READ_LAT  = 1,
  parameter int MAX_WORDS = 7056,
  parameter int CNT_W     = 13
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             clka,
  output logic             rsta,
  output logic             ena,
  output logic [31:0]      addra,
  output logic [31:0]      dina,
  output logic [3:0]       wea,
  input  logic [31:0]      douta,
  output logic             clkb,
  output logic             rstb,
  output logic             enb,
  output logic [31:0]      addrb,
  output logic [31:0]      dinb,
  output logic [3:0]       web,
  input  logic [31:0]      doutb
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]    wr_idx_q, wr_idx_d;
  logic [READ_LAT-1:0] vld_q, vld_d;

  logic             rd_fire;
  logic             wr_fire;
  logic [CNT_W-1:0] n_clamped;

  // Port A data byte 3, port B read data and the address byte offsets carry
  // no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{doutb, douta[31:24], src_base[1:0], dst_base[1:0]};

  assign rd_fire   = (state_q == S_READ);
  assign wr_fire   = vld_q[READ_LAT-1];
  assign n_clamped = (word_cnt > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_cnt;

  // Next-state, counter and read-valid pipeline logic.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    n_d      = n_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    // Valid bit enters at the bottom and leaves READ_LAT cycles later,
    // lining up with the cycle douta holds the matching word.
    vld_d    = READ_LAT'({vld_q, rd_fire});

    if (rd_fire) rd_idx_d = rd_idx_q + CNT_W'(1);
    if (wr_fire) wr_idx_d = wr_idx_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          src_d    = {src_base[31:2], 2'b00};
          dst_d    = {dst_base[31:2], 2'b00};
          n_d      = n_clamped;
          rd_idx_d = '0;
          wr_idx_d = '0;
          state_d  = (n_clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (rd_idx_q == n_q - CNT_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_fire && (wr_idx_q == n_q - CNT_W'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition, including the one into DONE.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      vld_d   = '0;
    end
  end

  // State, latched job parameters, counters and pipeline with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      n_q      <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      n_q      <= n_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      vld_q    <= vld_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);

  assign clka  = clk;
  assign clkb  = clk;
  assign rsta  = ~rstn;
  assign rstb  = ~rstn;
  assign dina  = 32'h0000_0000;
  assign wea   = 4'b0000;

  // Read port: word index scaled to a byte offset, wrapping modulo 2^32.
  assign ena   = rd_fire;
  assign addra = rd_fire ? (src_q + {{(30-CNT_W){1'b0}}, rd_idx_q, 2'b00}) : 32'h0;

  // Write port: fires in the cycle the matching read data is on douta.
  assign enb   = wr_fire;
  assign web   = wr_fire ? 4'hF : 4'h0;
  assign addrb = wr_fire ? (dst_q + {{(30-CNT_W){1'b0}}, wr_idx_q, 2'b00}) : 32'h0;
  assign dinb  = wr_fire ? {8'h00, douta[23:0]} : 32'h0;

endmodule
